// File: rtl/shift_pkg.sv
// Shared types for the WISC shift/rotate execute stage: op encodings, stage records, widths.
package shift_pkg;

    localparam int SHIFT_AMT_W  = 4;
    localparam int SHIFT_DATA_W = 16;
    // Tags wider than this are truncated inside the pipeline.
    localparam int SHIFT_TAG_W  = 3;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } shift_op_t;

    typedef struct packed {
        logic                    valid;
        logic [SHIFT_AMT_W-1:0]  ramt;
        logic [SHIFT_DATA_W-1:0] mask;
        logic [SHIFT_DATA_W-1:0] data;
        logic [SHIFT_TAG_W-1:0]  tag;
        logic                    err;
    } s1_t;

    typedef struct packed {
        logic                    valid;
        logic [SHIFT_DATA_W-1:0] data;
        logic [SHIFT_TAG_W-1:0]  tag;
        logic                    err;
    } s2_t;

    // Right-going shifts reuse the left rotator with amount (16 - amt) mod 16.
    function automatic logic [SHIFT_AMT_W-1:0] neg_amt(input logic [SHIFT_AMT_W-1:0] amt);
        return ~amt + 4'd1;
    endfunction

endpackage

// File: rtl/rotl16_mask.sv
// Combinational 16-bit left rotate by ramt followed by an AND with mask.
module rotl16_mask
    import shift_pkg::*;
(
    input  logic [SHIFT_DATA_W-1:0] data,
    input  logic [SHIFT_AMT_W-1:0]  ramt,
    input  logic [SHIFT_DATA_W-1:0] mask,
    output logic [SHIFT_DATA_W-1:0] result
);

    logic [SHIFT_DATA_W-1:0] rotated;

    // A right shift by 16 yields zero, which covers ramt = 0 without a special case.
    assign rotated = (data << ramt) | (data >> (5'd16 - {1'b0, ramt}));
    assign result  = rotated & mask;

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift/rotate execute unit (decode -> rotate+mask) with valid/ready handshake.
// Define SHIFT_ROR_EN to implement ROR; otherwise ROR retires with out_data = 0, out_err = 1.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    s1_t                     s1_q, s1_d;
    s2_t                     s2_q, s2_d;
    logic                    adv1, adv2, accept;
    logic [SHIFT_DATA_W-1:0] rot_result;

    // No skid buffer: in_ready is combinational from out_ready.
    assign adv2     = !s2_q.valid || out_ready;
    assign adv1     = !s1_q.valid || adv2;
    assign in_ready = adv1 && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        s1_d.valid = accept;
        s1_d.data  = SHIFT_DATA_W'(in_data);
        s1_d.tag   = SHIFT_TAG_W'(in_tag);
        s1_d.ramt  = in_amt;
        s1_d.mask  = '1;
        s1_d.err   = 1'b0;
        case (shift_op_t'(in_op))
            OP_ROL: ;
            OP_SLL: s1_d.mask = 16'hFFFF << in_amt;
            OP_SRL: begin
                s1_d.ramt = neg_amt(in_amt);
                s1_d.mask = 16'hFFFF >> in_amt;
            end
            OP_ROR: begin
`ifdef SHIFT_ROR_EN
                s1_d.ramt = neg_amt(in_amt);
`else
                s1_d.mask = '0;
                s1_d.err  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    rotl16_mask u_rotl16_mask (
        .data   (s1_q.data),
        .ramt   (s1_q.ramt),
        .mask   (s1_q.mask),
        .result (rot_result)
    );

    assign s2_d = '{valid: s1_q.valid, data: rot_result, tag: s1_q.tag, err: s1_q.err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too, since out_data/out_tag/out_err must read 0 in reset.
            s1_q <= '0;
            s2_q <= '0;
        end else if (flush) begin
            // NOTE: non-blocking so both stages update from pre-edge values.
            s1_q.valid <= 1'b0;
            s2_q.valid <= 1'b0;
        end else begin
            if (adv2) s2_q <= s2_d;
            if (adv1) s1_q <= s1_d;
        end
    end

    assign out_valid = s2_q.valid;
    assign out_data  = WIDTH'(s2_q.data);
    assign out_tag   = TAG_W'(s2_q.tag);
    assign out_err   = s2_q.err;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed cases plus randomized traffic vs a queue model.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [15:0] in_data = 16'd0;
    logic [3:0]  in_amt = 4'd0;
    logic [2:0]  in_tag = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_tag;
    logic        out_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_exec_stage #(.WIDTH(16), .TAG_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference result {err, data} from plain shift arithmetic.
    function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
        int unsigned x = d;
        int unsigned n = a;
        case (op)
            2'b00: return {1'b0, 16'(((x << n) | (x >> (16 - n))) & 32'hFFFF)};
            2'b01: return {1'b0, 16'((x << n) & 32'hFFFF)};
`ifdef SHIFT_ROR_EN
            2'b10: return {1'b0, 16'(((x >> n) | (x << (16 - n))) & 32'hFFFF)};
`else
            2'b10: return {1'b1, 16'h0000};
`endif
            default: return {1'b0, 16'(x >> n)};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] a, input logic [2:0] t);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_tag   = t;
    endtask

    task automatic single_op(input string name, input logic [1:0] op, input logic [15:0] d,
                             input logic [3:0] a, input logic [2:0] t,
                             input logic [15:0] exp_d, input logic exp_e);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, op, d, a, t);
        #1 check({name, "_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_tag"}, out_tag, t);
        check({name, "_err"}, out_err, exp_e);
        @(negedge clk);
        check({name, "_drain"}, out_valid, 0);
    endtask

    initial begin
        exp_t        e;
        logic [16:0] m;
        logic        exp_ready;

        // Reset state
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Directed single ops
        single_op("rol", 2'b00, 16'h8001, 4'd1, 3'd5, 16'h0003, 1'b0);
        single_op("sll", 2'b01, 16'hFFFF, 4'd4, 3'd2, 16'hFFF0, 1'b0);
        single_op("srl15", 2'b11, 16'h8000, 4'd15, 3'd3, 16'h0001, 1'b0);
        single_op("srl0", 2'b11, 16'h1234, 4'd0, 3'd4, 16'h1234, 1'b0);
`ifdef SHIFT_ROR_EN
        single_op("ror", 2'b10, 16'h0001, 4'd1, 3'd6, 16'h8000, 1'b0);
`else
        single_op("ror", 2'b10, 16'h0001, 4'd1, 3'd6, 16'h0000, 1'b1);
`endif

        // Back-to-back under backpressure, then in-order retirement
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h1111, 4'd1, 3'd1);
        #1 check("bp_ready1", in_ready, 1);
        @(negedge clk);
        drive(1'b1, 2'b00, 16'h2222, 4'd2, 3'd2);
        #1 check("bp_ready2", in_ready, 1);
        @(negedge clk);
        drive(1'b1, 2'b00, 16'h3333, 4'd3, 3'd3);
        #1 check("bp_ready3", in_ready, 0);
        check("bp_hold_tag", out_tag, 1);
        check("bp_hold_data0", out_data, 16'h2222);
        @(negedge clk);
        check("bp_ready4", in_ready, 0);
        check("bp_hold_data1", out_data, 16'h2222);
        out_ready = 1'b1;
        #1 check("bp_ready_comb", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_ret2_tag", out_tag, 2);
        check("bp_ret2_data", out_data, 16'h8888);
        @(negedge clk);
        check("bp_ret3_tag", out_tag, 3);
        check("bp_ret3_data", out_data, 16'h9999);
        @(negedge clk);
        check("bp_empty", out_valid, 0);

        // Flush with a full pipeline and a pending input
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 16'hABCD, 4'd1, 3'd1);
        @(negedge clk);
        drive(1'b1, 2'b01, 16'hABCD, 4'd2, 3'd2);
        @(negedge clk);
        drive(1'b1, 2'b01, 16'hABCD, 4'd3, 3'd3);
        check("fl_full", out_valid, 1);
        flush = 1'b1;
        #1 check("fl_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 check("fl_valid", out_valid, 0);
        check("fl_ready_after", in_ready, 1);
        repeat (2) begin
            @(negedge clk);
            check("fl_no_accept", out_valid, 0);
        end

        // Asynchronous reset mid-cycle with two ops in flight
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h5A5A, 4'd0, 3'd7);
        @(negedge clk);
        drive(1'b1, 2'b00, 16'hA5A5, 4'd0, 3'd6);
        @(negedge clk);
        in_valid = 1'b0;
        check("rp_full", out_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rp_valid", out_valid, 0);
        check("rp_data", out_data, 0);
        check("rp_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("rp_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("rp_no_result", out_valid, 0);
        end

        // Randomized traffic against the queue model
        sb.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, 2'($urandom), 16'($urandom), 4'($urandom), 3'($urandom));
            out_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 49) == 0;
            #1;
            if (flush) begin
                check("rnd_flush_ready", in_ready, 0);
                sb.delete();
            end else begin
                exp_ready = (sb.size() < 2) || out_ready;
                check("rnd_ready", in_ready, exp_ready);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("rnd_spurious", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rnd_data", out_data, e.data);
                        check("rnd_tag", out_tag, e.tag);
                        check("rnd_err", out_err, e.err);
                    end
                end
                if (in_valid && in_ready) begin
                    m = model(in_op, in_data, in_amt);
                    sb.push_back('{data: m[15:0], tag: in_tag, err: m[16]});
                end
            end
        end

        // Drain within a bounded number of cycles
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("drain_spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("drain_data", out_data, e.data);
                    check("drain_tag", out_tag, e.tag);
                    check("drain_err", out_err, e.err);
                end
            end
            @(negedge clk);
        end
        check("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
